// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: store/load/fetch requesters share one memory port.
// Ports: clk, reset, per-requester req/addr(/wdata), gnt/done pulses,
//   flush, rdata, mem_* memory side, busy.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_req,
  input  logic [WORD_SIZE-1:0] s_addr,
  input  logic [WORD_SIZE-1:0] s_wdata,
  input  logic                 l_req,
  input  logic [WORD_SIZE-1:0] l_addr,
  input  logic                 f_req,
  input  logic [WORD_SIZE-1:0] f_addr,
  input  logic                 flush,
  output logic                 s_gnt,
  output logic                 l_gnt,
  output logic                 f_gnt,
  output logic                 s_done,
  output logic                 l_done,
  output logic                 f_done,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {
    OWN_NONE, OWN_S, OWN_L, OWN_F
  } owner_t;

  state_t                 state_q;
  owner_t                 owner_q;
  owner_t                 win;
  logic [CW-1:0]          starve_q;
  logic                   supp_q;
  logic                   s_gnt_q, l_gnt_q, f_gnt_q;
  logic                   s_done_q, l_done_q, f_done_q;
  logic [WORD_SIZE-1:0]   rdata_q;
  logic                   mem_req_q, mem_we_q, busy_q;
  logic [WORD_SIZE-1:0]   mem_addr_q, mem_wdata_q;
  logic                   f_elig;
  logic                   promote;

  // A flush in the same cycle makes a fetch request ineligible.
  assign f_elig  = f_req & ~flush;
  assign promote = (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    win = OWN_NONE;
    if (promote && f_elig) win = OWN_F;
    else if (s_req)        win = OWN_S;
    else if (l_req)        win = OWN_L;
    else if (f_elig)       win = OWN_F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      supp_q      <= 1'b0;
      s_gnt_q     <= 1'b0;
      l_gnt_q     <= 1'b0;
      f_gnt_q     <= 1'b0;
      s_done_q    <= 1'b0;
      l_done_q    <= 1'b0;
      f_done_q    <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      s_gnt_q  <= 1'b0;
      l_gnt_q  <= 1'b0;
      f_gnt_q  <= 1'b0;
      s_done_q <= 1'b0;
      l_done_q <= 1'b0;
      f_done_q <= 1'b0;
      if (flush) starve_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (win != OWN_NONE) begin
            state_q   <= BUSY;
            owner_q   <= win;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            supp_q    <= 1'b0;
            mem_we_q  <= (win == OWN_S);
            mem_wdata_q <= (win == OWN_S) ? s_wdata : '0;
            unique case (win)
              OWN_S: begin
                s_gnt_q    <= 1'b1;
                mem_addr_q <= s_addr;
              end
              OWN_L: begin
                l_gnt_q    <= 1'b1;
                mem_addr_q <= l_addr;
              end
              default: begin
                f_gnt_q    <= 1'b1;
                mem_addr_q <= f_addr;
              end
            endcase
            // Fetch lost an arbitration it was competing in.
            if (win == OWN_F)
              starve_q <= '0;
            else if (f_elig && !promote)
              starve_q <= starve_q + 1'b1;
          end
        end
        BUSY: begin
          // A flushed fetch still completes on the memory side,
          // but its result is dropped.
          if (flush && owner_q == OWN_F) supp_q <= 1'b1;
          if (mem_ready) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            mem_we_q  <= 1'b0;
            unique case (owner_q)
              OWN_S: s_done_q <= 1'b1;
              OWN_L: begin
                l_done_q <= 1'b1;
                rdata_q  <= mem_rdata;
              end
              OWN_F: begin
                if (!(supp_q || flush)) begin
                  f_done_q <= 1'b1;
                  rdata_q  <= mem_rdata;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_gnt     = s_gnt_q;
  assign l_gnt     = l_gnt_q;
  assign f_gnt     = f_gnt_q;
  assign s_done    = s_done_q;
  assign l_done    = l_done_q;
  assign f_done    = f_done_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
